rx_data_route: RTL and testbench

Receive-side counterpart of the transmit data select path. Takes bytes strobed in by the UART receiver and routes them into one of two stores:
- a single holding register (character mode, FIFO_EN=0), or
- an RX FIFO (FIFO_EN=1).

It presents the head byte to the CPU/DMA reader, raises the DMA request per the 16550-style mode rules (DMA_MODE & FIFO_EN selects burst mode), and flags overrun.

---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/rx_fifo_mem.sv | 46 ++++
 rtl/rx_data_route.sv | 212 +++++++++++++++++++++
 tb/tb_rx_data_route.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive data path.
// Provides the default character width, the RX trigger-level constants,
// the DMA request state enum and a helper that decodes the 2-bit
// trigger-level field into a byte count.
package uart_rx_pkg;

  localparam int RX_DATA_W = 8;

  // Number of queued bytes needed to start a DMA burst for each trig_lvl code
  localparam int TRIG_1  = 1;
  localparam int TRIG_4  = 4;
  localparam int TRIG_8  = 8;
  localparam int TRIG_14 = 14;

  typedef enum logic {
    D_IDLE  = 1'b0,
    D_BURST = 1'b1
  } dma_state_e;

  // Map the trig_lvl code (00/01/10/11) onto its byte threshold
  function automatic int trig_decode(input logic [1:0] lvl);
    int thr;
    thr = TRIG_1;
    case (lvl)
      2'b00: thr = TRIG_1;
      2'b01: thr = TRIG_4;
      2'b10: thr = TRIG_8;
      2'b11: thr = TRIG_14;
      default: thr = TRIG_1;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// RX FIFO storage: a simple RAM written at wr_ptr plus a registered head
// register that the owner reloads whenever the head entry changes.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset (head register only)
//   wr_en/wr_ptr/wr_data - write port
//   head_ld        - reload the head register this cycle
//   head_bypass    - take the head straight from wr_data instead of the RAM
//   head_ptr       - RAM address to read the new head from
//   head           - registered head byte
module rx_fifo_mem #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              head_ld,
  input  logic              head_bypass,
  input  logic [PTR_W-1:0]  head_ptr,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  // Storage array; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head register. The bypass covers a push into an empty FIFO and a
  // push+pop on a single-entry FIFO, where the RAM slot is written in the
  // same cycle and cannot be read back yet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
    end else if (head_ld) begin
      head <= head_bypass ? wr_data : mem[head_ptr];
    end
  end

endmodule

// File: rtl/rx_data_route.sv
// Receive data routing: steers bytes from the UART receiver either into a
// one-entry holding register (character mode) or into the RX FIFO (FIFO
// mode), presents the head byte to the reader, tracks overrun and drives
// the 16550-style DMA request.
// Ports:
//   m_clk, reset          - clock, asynchronous active-low reset
//   FIFO_EN, DMA_MODE     - store mode and DMA mode selects
//   trig_lvl              - burst DMA trigger level code
//   fifo_clr              - flush pulse
//   rx_data, rx_valid     - received byte and its strobe
//   rd_en, dma_ack        - CPU / DMA pop strobes
//   ovr_clr               - overrun clear pulse
//   data_out, data_ready  - head byte and non-empty flag
//   overrun               - sticky overrun flag
//   dma_req               - registered DMA request
//   fifo_count            - entries held
module rx_data_route
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = RX_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic              FIFO_EN,
  input  logic              DMA_MODE,
  input  logic [1:0]        trig_lvl,
  input  logic              fifo_clr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rd_en,
  input  logic              dma_ack,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              overrun,
  output logic              dma_req,
  output logic [PTR_W:0]    fifo_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic              fifo_en_q;
  logic              flush;
  logic              pop;
  logic              full;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              char_load;
  logic              ovr_evt;
  logic              head_ld;
  logic              head_bypass;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] hold_reg;
  logic              out_sel;
  logic              burst_mode;
  logic [PTR_W:0]    trig_cnt;
  logic              dma_req_d;
  dma_state_e        dma_state;
  dma_state_e        dma_state_d;

  // Operating mode is taken from the registered FIFO_EN; any difference
  // between the live and registered copy is a mode change and flushes.
  assign flush      = fifo_clr | (FIFO_EN ^ fifo_en_q);
  assign data_ready = (count_q != '0);
  assign full       = (count_q == DEPTH_C);
  assign pop        = (rd_en | dma_ack) & data_ready;

  assign fifo_push  = fifo_en_q & rx_valid & ~flush & (~full | pop);
  assign fifo_pop   = fifo_en_q & pop & ~flush;
  assign char_load  = ~fifo_en_q & rx_valid & ~flush;
  assign ovr_evt    = rx_valid & ~flush & ~pop & (fifo_en_q ? full : data_ready);

  // The FIFO head changes on a push into empty, or on a pop that leaves
  // something behind (including a pop of the last entry paired with a push).
  assign head_ld     = (fifo_push & (count_q == '0)) |
                       (fifo_pop & (fifo_push | (count_q != ONE_C)));
  assign head_bypass = (count_q == '0) | (count_q == ONE_C);

  assign burst_mode = DMA_MODE & fifo_en_q;
  assign trig_cnt   = (PTR_W+1)'(trig_decode(trig_lvl));

  // data_out follows whichever store was loaded most recently, so that an
  // empty store (including right after a mode switch) keeps the last byte.
  assign data_out   = out_sel ? fifo_head : hold_reg;
  assign fifo_count = count_q;

  rx_fifo_mem #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk         (m_clk),
    .reset       (reset),
    .wr_en       (fifo_push),
    .wr_ptr      (wr_ptr),
    .wr_data     (rx_data),
    .head_ld     (head_ld),
    .head_bypass (head_bypass),
    .head_ptr    (rd_ptr + PTR_W'(1)),
    .head        (fifo_head)
  );

  // Next entry count for both store types
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (fifo_en_q) begin
      count_d = count_q + (PTR_W+1)'(fifo_push) - (PTR_W+1)'(fifo_pop);
    end else if (char_load) begin
      count_d = ONE_C;
    end else if (pop) begin
      count_d = '0;
    end
  end

  // Count, pointers and the mode register
  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      fifo_en_q <= 1'b0;
      count_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      fifo_en_q <= FIFO_EN;
      count_q   <= count_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (fifo_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (fifo_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Character-mode holding register and output source select
  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      hold_reg <= '0;
      out_sel  <= 1'b0;
    end else begin
      if (char_load) begin
        hold_reg <= rx_data;
        out_sel  <= 1'b0;
      end else if (head_ld) begin
        out_sel  <= 1'b1;
      end
    end
  end

  // Sticky overrun; a new event wins over a simultaneous clear
  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (ovr_evt) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  // DMA FSM state register; dma_req is registered alongside it
  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      dma_state <= D_IDLE;
      dma_req   <= 1'b0;
    end else begin
      dma_state <= dma_state_d;
      dma_req   <= dma_req_d;
    end
  end

  // DMA next state, evaluated on the count being written this cycle so the
  // request moves together with fifo_count
  always_comb begin
    dma_state_d = dma_state;
    if (!burst_mode || flush) begin
      dma_state_d = D_IDLE;
    end else if (dma_state == D_IDLE) begin
      if (count_d >= trig_cnt) begin
        dma_state_d = D_BURST;
      end
    end else begin
      if (count_d == '0) begin
        dma_state_d = D_IDLE;
      end
    end
  end

  // DMA request: burst state in burst mode, otherwise simply non-empty
  always_comb begin
    dma_req_d = 1'b0;
    if (burst_mode) begin
      dma_req_d = (dma_state_d == D_BURST);
    end else begin
      dma_req_d = (count_d != '0);
    end
  end

endmodule

// File: tb/tb_rx_data_route.sv
// Self-checking bench for rx_data_route: a table of directed vectors,
// hand-written corner sequences and a randomized run against a queue-based
// reference model.
module tb_rx_data_route;

  logic       m_clk = 1'b0;
  logic       reset;
  logic       FIFO_EN, DMA_MODE;
  logic [1:0] trig_lvl;
  logic       fifo_clr, rx_valid, rd_en, dma_ack, ovr_clr;
  logic [7:0] rx_data;
  logic [7:0] data_out;
  logic       data_ready, overrun, dma_req;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       fen;
    logic       dmode;
    logic [1:0] trig;
    logic       clr;
    logic       rxv;
    logic [7:0] data;
    logic       rd;
    logic       ack;
    logic       oclr;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] out;
    logic       rdy;
    logic       ovr;
    logic       req;
    logic [4:0] cnt;
  } vec_t;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovr, m_req, m_active, m_prev_en;
  logic [7:0] m_out;

  logic       cur_fen, cur_dmode;
  logic [1:0] cur_trig;

  rx_data_route dut (
    .m_clk      (m_clk),
    .reset      (reset),
    .FIFO_EN    (FIFO_EN),
    .DMA_MODE   (DMA_MODE),
    .trig_lvl   (trig_lvl),
    .fifo_clr   (fifo_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rd_en      (rd_en),
    .dma_ack    (dma_ack),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_ready (data_ready),
    .overrun    (overrun),
    .dma_req    (dma_req),
    .fifo_count (fifo_count)
  );

  always #5 m_clk = ~m_clk;

  function automatic int trigVal(input logic [1:0] t);
    int v;
    case (t)
      2'b00: v = 1;
      2'b01: v = 4;
      2'b10: v = 8;
      default: v = 14;
    endcase
    return v;
  endfunction

  function automatic void modelReset();
    mq.delete();
    m_ovr     = 1'b0;
    m_req     = 1'b0;
    m_active  = 1'b0;
    m_prev_en = 1'b0;
    m_out     = 8'h00;
  endfunction

  // One clock edge of the behavioural model: a bounded byte queue whose
  // capacity is 1 in character mode and 16 in FIFO mode
  function automatic void modelStep(input stim_t s);
    logic flush, pop, evt, burst;
    int   cap;
    flush = s.clr || (s.fen != m_prev_en);
    cap   = m_prev_en ? 16 : 1;
    pop   = (s.rd || s.ack) && (mq.size() > 0);
    evt   = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (s.rxv && mq.size() == cap && !pop) evt = 1'b1;
      if (pop) void'(mq.pop_front());
      if (s.rxv) begin
        if (mq.size() < cap) mq.push_back(s.data);
        else if (!m_prev_en) mq[0] = s.data;
      end
    end
    if (evt) m_ovr = 1'b1;
    else if (s.oclr) m_ovr = 1'b0;
    if (mq.size() > 0) m_out = mq[0];
    burst = s.dmode && s.fen;
    if (!burst || flush) m_active = 1'b0;
    else if (!m_active && mq.size() >= trigVal(s.trig)) m_active = 1'b1;
    else if (m_active && mq.size() == 0) m_active = 1'b0;
    m_req = burst ? m_active : (mq.size() > 0);
    m_prev_en = s.fen;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    FIFO_EN  = s.fen;
    DMA_MODE = s.dmode;
    trig_lvl = s.trig;
    fifo_clr = s.clr;
    rx_valid = s.rxv;
    rx_data  = s.data;
    rd_en    = s.rd;
    dma_ack  = s.ack;
    ovr_clr  = s.oclr;
    modelStep(s);
    @(posedge m_clk);
    #1;
    fifo_clr = 1'b0;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    dma_ack  = 1'b0;
    ovr_clr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".data_out"},   32'(data_out),   32'(m_out));
    checkVal({tag, ".data_ready"}, 32'(data_ready), 32'(mq.size() > 0));
    checkVal({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
    checkVal({tag, ".dma_req"},    32'(dma_req),    32'(m_req));
    checkVal({tag, ".fifo_count"}, 32'(fifo_count), 32'(mq.size()));
  endtask

  task automatic drive(input logic rxv, input logic [7:0] d, input logic rd,
                       input logic ack, input logic clr, input logic oclr);
    stim_t s;
    s.fen = cur_fen; s.dmode = cur_dmode; s.trig = cur_trig;
    s.clr = clr; s.rxv = rxv; s.data = d; s.rd = rd; s.ack = ack; s.oclr = oclr;
    applyStimulus(s);
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic fen, input logic dmode, input logic [1:0] trig,
                              input logic clr, input logic rxv, input logic [7:0] data,
                              input logic rd, input logic ack, input logic oclr,
                              input logic [7:0] out, input logic rdy, input logic ovr,
                              input logic req, input logic [4:0] cnt);
    vec_t v;
    v.s.fen = fen; v.s.dmode = dmode; v.s.trig = trig; v.s.clr = clr; v.s.rxv = rxv;
    v.s.data = data; v.s.rd = rd; v.s.ack = ack; v.s.oclr = oclr;
    v.out = out; v.rdy = rdy; v.ovr = ovr; v.req = req; v.cnt = cnt;
    return v;
  endfunction

  // Test sequence
  initial begin
    vec_t vecs[$];

    //           fen dm trg clr rxv data   rd ack oclr   out   rdy ovr req cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h41, 0, 0, 0,  8'h41, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h42, 0, 0, 0,  8'h42, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 1,  8'h42, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h43, 1, 0, 0,  8'h43, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0,  8'h43, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0,  8'h43, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h44, 0, 0, 1,  8'h44, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h45, 0, 0, 1,  8'h45, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 1,  8'h45, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h46, 0, 0, 0,  8'h45, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h47, 0, 0, 0,  8'h47, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 0,  8'h47, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0,  8'h47, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 8'h11, 0, 0, 0,  8'h11, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 8'h22, 0, 0, 0,  8'h11, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, 0, 0,  8'h22, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 8'h33, 1, 0, 0,  8'h33, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 0,  8'h33, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 8'h44, 0, 0, 0,  8'h33, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 1, 0, 1, 8'h55, 0, 0, 0,  8'h33, 1, 0, 0, 3));
    vecs.push_back(mk(1, 1, 1, 0, 1, 8'h66, 0, 0, 0,  8'h33, 1, 0, 1, 4));
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 1, 0,  8'h44, 1, 0, 1, 3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 1, 0,  8'h55, 1, 0, 1, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 1, 0,  8'h66, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 1, 0,  8'h66, 0, 0, 0, 0));

    // Reset state
    reset = 1'b0;
    FIFO_EN = 1'b0; DMA_MODE = 1'b0; trig_lvl = 2'b00;
    fifo_clr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rd_en = 1'b0; dma_ack = 1'b0; ovr_clr = 1'b0;
    modelReset();
    repeat (2) @(posedge m_clk);
    #1;
    checkVal("reset.data_out",   32'(data_out),   32'h0);
    checkVal("reset.data_ready", 32'(data_ready), 32'h0);
    checkVal("reset.overrun",    32'(overrun),    32'h0);
    checkVal("reset.dma_req",    32'(dma_req),    32'h0);
    checkVal("reset.fifo_count", 32'(fifo_count), 32'h0);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      checkVal($sformatf("vec%0d.data_out", i),   32'(data_out),   32'(vecs[i].out));
      checkVal($sformatf("vec%0d.data_ready", i), 32'(data_ready), 32'(vecs[i].rdy));
      checkVal($sformatf("vec%0d.overrun", i),    32'(overrun),    32'(vecs[i].ovr));
      checkVal($sformatf("vec%0d.dma_req", i),    32'(dma_req),    32'(vecs[i].req));
      checkVal($sformatf("vec%0d.fifo_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
    end

    // FIFO fill to 16, overflow, drain in order
    cur_fen = 1'b1; cur_dmode = 1'b0; cur_trig = 2'b00;
    idle();
    for (int i = 1; i <= 16; i++) push(8'(i));
    checkVal("fill.fifo_count", 32'(fifo_count), 32'd16);
    checkVal("fill.overrun",    32'(overrun),    32'h0);
    push(8'h11);
    checkVal("ovf.fifo_count", 32'(fifo_count), 32'd16);
    checkVal("ovf.overrun",    32'(overrun),    32'h1);
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("drain%0d.data_out", i), 32'(data_out), 32'(i + 1));
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkVal("drain.data_ready", 32'(data_ready), 32'h0);
    checkVal("drain.hold",       32'(data_out),   32'h10);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("oclr.overrun", 32'(overrun), 32'h0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    drive(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("fullrw.fifo_count", 32'(fifo_count), 32'd16);
    checkVal("fullrw.overrun",    32'(overrun),    32'h0);
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("fullrw%0d.data_out", i), 32'(data_out),
               (i < 15) ? 32'(8'hA1 + 8'(i)) : 32'hB0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkVal("fullrw.empty", 32'(data_ready), 32'h0);

    // Single-mode DMA with a double strobe
    push(8'h55);
    checkVal("single.dma_req", 32'(dma_req), 32'h1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("single.pop.dma_req",    32'(dma_req),    32'h0);
    checkVal("single.pop.fifo_count", 32'(fifo_count), 32'h0);

    // Mode toggle with five bytes queued
    cur_dmode = 1'b1; cur_trig = 2'b11;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    checkOutput("toggle.pre");
    cur_fen = 1'b0;
    idle();
    checkVal("toggle.fifo_count", 32'(fifo_count), 32'h0);
    checkVal("toggle.data_ready", 32'(data_ready), 32'h0);
    checkVal("toggle.dma_req",    32'(dma_req),    32'h0);

    // Asynchronous reset in the middle of a burst
    cur_fen = 1'b1; cur_trig = 2'b00;
    idle();
    push(8'h77);
    push(8'h78);
    checkVal("burst.dma_req", 32'(dma_req), 32'h1);
    #3 reset = 1'b0;
    #1;
    checkVal("areset.data_out",   32'(data_out),   32'h0);
    checkVal("areset.data_ready", 32'(data_ready), 32'h0);
    checkVal("areset.overrun",    32'(overrun),    32'h0);
    checkVal("areset.dma_req",    32'(dma_req),    32'h0);
    checkVal("areset.fifo_count", 32'(fifo_count), 32'h0);
    @(posedge m_clk);
    #1;
    reset = 1'b1;
    modelReset();

    // Randomized run against the reference model
    for (int n = 0; n < 800; n++) begin
      stim_t s;
      if ($urandom_range(49) == 0) cur_fen = ~cur_fen;
      if ($urandom_range(29) == 0) cur_dmode = ~cur_dmode;
      if ($urandom_range(39) == 0) cur_trig = 2'($urandom_range(3));
      s.fen   = cur_fen;
      s.dmode = cur_dmode;
      s.trig  = cur_trig;
      s.clr   = ($urandom_range(59) == 0);
      s.rxv   = ($urandom_range(9) < 6);
      s.data  = 8'($urandom);
      s.rd    = (n < 400) ? ($urandom_range(7) == 0) : ($urandom_range(2) == 0);
      s.ack   = ($urandom_range(7) == 0);
      s.oclr  = ($urandom_range(11) == 0);
      applyStimulus(s);
      checkOutput($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
